// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit divisor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package uart_pkg;

  // Frame-level states shared by the RX and TX blocks.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // 100 MHz system clock / 4 Mbaud line rate.
  localparam int CLKS_PER_BIT_DEF = 25;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reset value is parameterized.
// Latency: 2 clk from input change to q.
// Backpressure: none (free-running level path).
// Ports: clk, rst (async active-high), d (async input), q (synchronized output).
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: serial line in, one byte plus a one-cycle done strobe out.
// Latency: strobe 238 clk (default divisor) after the synchronized start edge is seen.
// Backpressure: none; the consumer must take rx_data on the strobe (it holds until the next good frame).
// Ports: clk, rst (async active-high), rx_in (async serial line, idle high),
//        rx_enable_signal (low forces IDLE), rx_done_signal (1-cycle strobe), rx_data[7:0].
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic       rx_enable_signal,
  output logic       rx_done_signal,
  output logic [7:0] rx_data
);

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

  logic          rxs;
  uart_state_t   state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    sh;

  // Reset to 1 so a reset never looks like a start bit.
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_in),
    .q   (rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      idx            <= '0;
      sh             <= '0;
      rx_data        <= 8'h00;
      rx_done_signal <= 1'b0;
    end else begin
      rx_done_signal <= 1'b0;
      if (state != IDLE && !rx_enable_signal) begin
        // Disable mid-frame abandons the byte silently.
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_enable_signal && !rxs) begin
              state <= START;
              cnt   <= '0;
            end
          end
          START: begin
            // Re-check the line at mid start bit to reject glitches; this
            // also aligns all later samples to mid-bit.
            if (cnt == HALF) begin
              cnt <= '0;
              if (!rxs) begin
                state <= DATA;
                idx   <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          DATA: begin
            if (cnt == LAST) begin
              sh[idx] <= rxs;
              cnt     <= '0;
              if (idx == 3'd7) state <= STOP;
              else             idx   <= idx + 3'd1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          STOP: begin
            if (cnt == LAST) begin
              state <= IDLE;
              cnt   <= '0;
              // A low stop bit is a framing error: drop the byte.
              if (rxs) begin
                rx_data        <= sh;
                rx_done_signal <= 1'b1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: 250 ns bits on a 10 ns clock, strobes logged on the falling edge.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic       rx_enable_signal;
  logic       rx_done_signal;
  logic [7:0] rx_data;

  int         n_asserts = 0;
  int         n_fail    = 0;

  // Strobe monitor: counts every high cycle, so a stretched strobe shows as extra counts.
  int         done_cnt  = 0;
  logic [7:0] done_log [0:15];
  time        last_done_t = 0;

  uart_rx #(.CLKS_PER_BIT(25)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_in            (rx_in),
    .rx_enable_signal (rx_enable_signal),
    .rx_done_signal   (rx_done_signal),
    .rx_data          (rx_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_done_signal === 1'b1) begin
      if (done_cnt < 16) done_log[done_cnt] = rx_data;
      done_cnt    = done_cnt + 1;
      last_done_t = $time;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one frame starting on a falling clock edge; line left idle high.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_in = 1'b0;
    #250;
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      #250;
    end
    rx_in = stop_bit;
    #250;
    rx_in = 1'b1;
  endtask

  time t_fall;

  initial begin
    rst              = 1'b1;
    rx_in            = 1'b1;
    rx_enable_signal = 1'b1;
    #100;
    rst = 1'b0;
    #10;
    chk("reset_data", {24'h0, rx_data}, 32'h00);
    chk("reset_done", {31'h0, rx_done_signal}, 32'h0);

    #1000;
    chk("idle_no_strobe", done_cnt, 0);

    // 0x55 with latency check: pin fall -> synced E 25 ns later -> strobe edge E+2380, seen at next negedge.
    t_fall = $time;
    send_byte(8'h55, 1'b1);
    chk("b55_count", done_cnt, 1);
    chk("b55_log", {24'h0, done_log[0]}, 32'h55);
    chk("b55_latency", 32'(last_done_t - t_fall), 32'd2410);
    #500;
    chk("b55_hold", {24'h0, rx_data}, 32'h55);
    chk("b55_single", done_cnt, 1);

    // Framing error: stop bit low on 0x3C.
    send_byte(8'h3C, 1'b0);
    #500;
    chk("ferr_no_strobe", done_cnt, 1);
    chk("ferr_data_kept", {24'h0, rx_data}, 32'h55);
    send_byte(8'hFF, 1'b1);
    #500;
    chk("ff_count", done_cnt, 2);
    chk("ff_data", {24'h0, rx_data}, 32'hFF);

    // Back-to-back frames, no idle gap.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    #500;
    chk("b2b_count", done_cnt, 4);
    chk("b2b_first", {24'h0, done_log[2]}, 32'hA5);
    chk("b2b_second", {24'h0, done_log[3]}, 32'h00);

    // 100 ns glitch, shorter than half a bit.
    rx_in = 1'b0;
    #100;
    rx_in = 1'b1;
    #1000;
    chk("glitch_no_strobe", done_cnt, 4);
    chk("glitch_data", {24'h0, rx_data}, 32'h00);

    // Enable dropped during data bits, held low until the line is idle again.
    fork
      send_byte(8'h12, 1'b1);
      begin
        #1000;
        rx_enable_signal = 1'b0;
        #1600;
        rx_enable_signal = 1'b1;
      end
    join
    #500;
    chk("abort_no_strobe", done_cnt, 4);
    send_byte(8'hC3, 1'b1);
    #500;
    chk("c3_count", done_cnt, 5);
    chk("c3_data", {24'h0, rx_data}, 32'hC3);

    // Reset during bit 5 of 0xE1; remaining bits are 1 so the line looks idle afterwards.
    fork
      send_byte(8'hE1, 1'b1);
      begin
        #1600;
        rst = 1'b1;
        #20;
        rst = 1'b0;
        #10;
        chk("rst_mid_data", {24'h0, rx_data}, 32'h00);
        chk("rst_mid_done", {31'h0, rx_done_signal}, 32'h0);
      end
    join
    #500;
    chk("rst_no_strobe", done_cnt, 5);
    send_byte(8'h5A, 1'b1);
    #500;
    chk("5a_count", done_cnt, 6);
    chk("5a_log", {24'h0, done_log[5]}, 32'h5A);
    chk("5a_data", {24'h0, rx_data}, 32'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
